// File: rtl/cfsr_period_monitor.sv
// cfsr_period_monitor
// Watches the state word of a small feedback shift register and measures the
// length of its cycle. Once a period is seen it keeps confirming that period.
// It counts disagreements and flags lock-up on a single repeated value.
//
// Output semantics: o_period_valid is a one-cycle strobe with no ready/accept
// path. A consumer must capture o_period on the cycle the strobe is high, or
// read o_period later, because it holds until the next measurement.
// o_state exposes the measurement FSM for debug and checker binding
// (0 = IDLE, 1 = MEASURE, 2 = VERIFY).
module cfsr_period_monitor #(
    parameter int WIDTH       = 4,
    parameter int STUCK_LIMIT = 3,
    parameter int LOCK_COUNT  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_cfsr,
    output logic [WIDTH:0]   o_period,
    output logic             o_period_valid,
    output logic             o_locked,
    output logic             o_stuck,
    output logic [7:0]       o_mismatch_cnt,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_VERIFY  = 2'd2
    } state_t;

    // The count reaches exactly 2^WIDTH when a full-length sequence has been
    // walked without the seed reappearing. That means the seed is transient.
    localparam logic [WIDTH:0] C_CNT_ONE = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] C_CNT_MAX = {1'b1, {WIDTH{1'b0}}};
    localparam logic [3:0]     C_LOCK    = 4'(LOCK_COUNT);
    localparam logic [3:0]     C_STUCK   = 4'(STUCK_LIMIT);

    state_t           r_state;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH:0]   r_cnt;
    logic [3:0]       r_match_run;
    logic [WIDTH-1:0] r_prev;
    logic [3:0]       r_same_run;
    logic [WIDTH:0]   r_period;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_stuck;
    logic [7:0]       r_mismatch_cnt;

    logic             w_seed_hit;
    logic             w_cnt_at_period;
    logic             w_cnt_below_period;
    logic [WIDTH:0]   w_cnt_inc;
    logic [3:0]       w_match_inc;
    logic [7:0]       w_mismatch_inc;
    logic [3:0]       w_same_next;

    assign w_seed_hit         = (i_cfsr == r_seed);
    assign w_cnt_at_period    = (r_cnt == r_period);
    assign w_cnt_below_period = (r_cnt < r_period);
    assign w_cnt_inc          = r_cnt + C_CNT_ONE;
    assign w_match_inc        = (r_match_run == 4'hF) ? 4'hF : (r_match_run + 4'd1);
    assign w_mismatch_inc     = (r_mismatch_cnt == 8'hFF) ? 8'hFF : (r_mismatch_cnt + 8'd1);

    // same_run == 0 only before the first sample after reset. So no
    // separate first-sample flag is needed.
    assign w_same_next = (r_same_run == 4'd0)   ? 4'd1 :
                         (i_cfsr != r_prev)     ? 4'd1 :
                         (r_same_run == 4'hF)   ? 4'hF :
                                                  (r_same_run + 4'd1);

    // Period measurement / verification FSM with its registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_seed         <= '0;
            r_cnt          <= '0;
            r_match_run    <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_mismatch_cnt <= '0;
        end else begin
            r_period_valid <= 1'b0;
            if (i_en) begin
                case (r_state)
                    S_IDLE: begin
                        r_seed  <= i_cfsr;
                        r_cnt   <= C_CNT_ONE;
                        r_state <= S_MEASURE;
                    end
                    S_MEASURE: begin
                        if (w_seed_hit) begin
                            r_period       <= r_cnt;
                            r_period_valid <= 1'b1;
                            r_cnt          <= C_CNT_ONE;
                            r_match_run    <= 4'd0;
                            r_state        <= S_VERIFY;
                        end else if (r_cnt == C_CNT_MAX) begin
                            // Seed never came back: restart from this sample.
                            r_seed         <= i_cfsr;
                            r_cnt          <= C_CNT_ONE;
                            r_mismatch_cnt <= w_mismatch_inc;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_VERIFY: begin
                        if (w_seed_hit && w_cnt_at_period) begin
                            r_match_run <= w_match_inc;
                            if (w_match_inc >= C_LOCK) begin
                                r_locked <= 1'b1;
                            end
                            r_cnt <= C_CNT_ONE;
                        end else if (w_seed_hit && w_cnt_below_period) begin
                            // Cycle got shorter: adopt the new length at once.
                            r_period       <= r_cnt;
                            r_period_valid <= 1'b1;
                            r_mismatch_cnt <= w_mismatch_inc;
                            r_match_run    <= 4'd0;
                            r_locked       <= 1'b0;
                            r_cnt          <= C_CNT_ONE;
                        end else if (!w_seed_hit && w_cnt_at_period) begin
                            // Seed missing where expected: remeasure, keep old period.
                            r_mismatch_cnt <= w_mismatch_inc;
                            r_locked       <= 1'b0;
                            r_match_run    <= 4'd0;
                            r_seed         <= i_cfsr;
                            r_cnt          <= C_CNT_ONE;
                            r_state        <= S_MEASURE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Lock-up detector: length of the current run of identical samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev     <= '0;
            r_same_run <= '0;
            r_stuck    <= 1'b0;
        end else if (i_en) begin
            r_prev     <= i_cfsr;
            r_same_run <= w_same_next;
            r_stuck    <= (w_same_next >= C_STUCK);
        end
    end

    assign o_period       = r_period;
    assign o_period_valid = r_period_valid;
    assign o_locked       = r_locked;
    assign o_stuck        = r_stuck;
    assign o_mismatch_cnt = r_mismatch_cnt;
    assign o_state        = r_state;

endmodule

// File: tb/tb_cfsr_period_monitor.sv
// Bench for cfsr_period_monitor: reference model plus expected-output queue,
// with directed checks at the points of interest.
module tb_cfsr_period_monitor;

  localparam int WIDTH       = 4;
  localparam int STUCK_LIMIT = 3;
  localparam int LOCK_COUNT  = 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] cfsr = '0;
  logic [WIDTH:0]   period;
  logic             period_valid;
  logic             locked;
  logic             stuck;
  logic [7:0]       mismatch_cnt;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  cfsr_period_monitor #(
    .WIDTH(WIDTH), .STUCK_LIMIT(STUCK_LIMIT), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cfsr(cfsr),
    .o_period(period), .o_period_valid(period_valid), .o_locked(locked),
    .o_stuck(stuck), .o_mismatch_cnt(mismatch_cnt), .o_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // {period[4:0], period_valid, locked, stuck, mismatch_cnt[7:0]}
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_seed, m_cnt, m_match, m_prev, m_same;
  int m_period, m_pv, m_locked, m_stuck, m_mcnt;

  function automatic int sat_inc(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_seed = 0; m_cnt = 0; m_match = 0; m_prev = 0; m_same = 0;
    m_period = 0; m_pv = 0; m_locked = 0; m_stuck = 0; m_mcnt = 0;
  endtask

  task automatic model_step(input logic e, input int c);
    m_pv = 0;
    if (!e) return;
    // run of identical samples
    if (m_same == 0)      m_same = 1;
    else if (c == m_prev) m_same = sat_inc(m_same, 15);
    else                  m_same = 1;
    m_prev  = c;
    m_stuck = (m_same >= STUCK_LIMIT) ? 1 : 0;
    // period tracking
    case (m_state)
      0: begin
        m_seed = c; m_cnt = 1; m_state = 1;
      end
      1: begin
        if (c == m_seed) begin
          m_period = m_cnt; m_pv = 1; m_cnt = 1; m_match = 0; m_state = 2;
        end else if (m_cnt == (1 << WIDTH)) begin
          m_seed = c; m_cnt = 1; m_mcnt = sat_inc(m_mcnt, 255);
        end else begin
          m_cnt++;
        end
      end
      default: begin
        if (c == m_seed && m_cnt == m_period) begin
          m_match = sat_inc(m_match, 15);
          if (m_match >= LOCK_COUNT) m_locked = 1;
          m_cnt = 1;
        end else if (c == m_seed && m_cnt < m_period) begin
          m_period = m_cnt; m_pv = 1; m_mcnt = sat_inc(m_mcnt, 255);
          m_match = 0; m_locked = 0; m_cnt = 1;
        end else if (c != m_seed && m_cnt == m_period) begin
          m_mcnt = sat_inc(m_mcnt, 255); m_locked = 0; m_match = 0;
          m_seed = c; m_cnt = 1; m_state = 1;
        end else begin
          m_cnt++;
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic e, input logic [WIDTH-1:0] v);
    logic [15:0] exp;
    @(negedge clk);
    en   = e;
    cfsr = v;
    model_step(e, int'(v));
    exp_q.push_back({5'(m_period), 1'(m_pv), 1'(m_locked), 1'(m_stuck), 8'(m_mcnt)});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    chk("sb_period",   32'(period),       32'(exp[15:11]));
    chk("sb_pvalid",   32'(period_valid), 32'(exp[10]));
    chk("sb_locked",   32'(locked),       32'(exp[9]));
    chk("sb_stuck",    32'(stuck),        32'(exp[8]));
    chk("sb_mismatch", 32'(mismatch_cnt), 32'(exp[7:0]));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    model_reset();
    chk("rst_period",   32'(period),       0);
    chk("rst_pvalid",   32'(period_valid), 0);
    chk("rst_locked",   32'(locked),       0);
    chk("rst_stuck",    32'(stuck),        0);
    chk("rst_mismatch", 32'(mismatch_cnt), 0);
    chk("rst_state",    32'(dbg_state),    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] seq3[3];
  logic [WIDTH-1:0] lfsr;
  int               n_en;

  initial begin
    seq3[0] = 4'h5; seq3[1] = 4'hA; seq3[2] = 4'h3;
    model_reset();
    apply_reset();

    // Hold with enable low: nothing may move.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'($urandom_range(0, 15)));
      chk("hold_period", 32'(period), 0);
    end

    // Basic period 3 and lock.
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, seq3[(k - 1) % 3]);
      if (k == 3) chk("basic_no_pv_yet", 32'(period_valid), 0);
      if (k == 4) begin
        chk("basic_period", 32'(period), 3);
        chk("basic_pvalid", 32'(period_valid), 1);
      end
      if (k == 9) chk("basic_prelock", 32'(locked), 0);
      if (k == 10) begin
        chk("basic_locked", 32'(locked), 1);
        chk("basic_mismatch", 32'(mismatch_cnt), 0);
      end
    end

    // Short period: seed 5 returns after only 2 samples.
    drive(1'b1, 4'hA);
    drive(1'b1, 4'h5);
    chk("short_period",   32'(period), 2);
    chk("short_pvalid",   32'(period_valid), 1);
    chk("short_locked",   32'(locked), 0);
    chk("short_mismatch", 32'(mismatch_cnt), 1);
    drive(1'b0, 4'h5);
    chk("gap_pvalid_low", 32'(period_valid), 0);

    // Relock on period 2, then reset while locked.
    drive(1'b1, 4'hA); drive(1'b1, 4'h5);
    drive(1'b1, 4'hA); drive(1'b1, 4'h5);
    chk("relock_locked", 32'(locked), 1);
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'($urandom_range(0, 15)));
      chk("post_rst_hold_locked", 32'(locked), 0);
    end

    // Transient seed 1 followed by 4,5 repeating.
    drive(1'b1, 4'h1);
    for (int k = 2; k <= 19; k++) begin
      drive(1'b1, (k % 2 == 0) ? 4'h4 : 4'h5);
      if (k == 16) chk("ovf_before", 32'(mismatch_cnt), 0);
      if (k == 17) chk("ovf_mismatch", 32'(mismatch_cnt), 1);
      if (k == 19) begin
        chk("ovf_period", 32'(period), 2);
        chk("ovf_pvalid", 32'(period_valid), 1);
      end
    end

    // Lock-up on zero.
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'h0);
      if (k == 2) chk("stuck_early", 32'(stuck), 0);
      if (k == 3) begin
        chk("stuck_set", 32'(stuck), 1);
        chk("stuck_period", 32'(period), 1);
      end
      if (k == 4) chk("stuck_locked", 32'(locked), 1);
    end
    drive(1'b1, 4'h8);
    chk("stuck_clear", 32'(stuck), 0);

    // Maximal-length sequence (x^4+x^3+1) with enable toggling.
    apply_reset();
    lfsr = 4'h1;
    n_en = 0;
    while (n_en < 46) begin
      drive(1'b1, lfsr);
      lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      n_en++;
      if (n_en == 16) begin
        chk("max_period", 32'(period), 15);
        chk("max_pvalid", 32'(period_valid), 1);
      end
      if (n_en == 45) chk("max_prelock", 32'(locked), 0);
      if (n_en == 46) begin
        chk("max_locked", 32'(locked), 1);
        chk("max_mismatch", 32'(mismatch_cnt), 0);
      end
      drive(1'b0, 4'($urandom_range(0, 15)));
      if (n_en == 16) chk("max_gap_pvalid", 32'(period_valid), 0);
    end

    // Random stimulus until the mismatch counter saturates.
    apply_reset();
    for (int k = 0; k < 4000; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)));
    end
    chk("saturated", 32'(mismatch_cnt), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
